rx_sfd_strip: RTL and testbench
===============================

# rx_sfd_strip

Receive-side framing stage between the GMII receive pins and the redundancy-voting stage. It locks onto the preamble and SFD, then forwards the frame body (destination MAC through last payload byte) as a gated byte stream. It withholds the 4 FCS bytes and checks CRC-32 over the body plus FCS. At end of frame it reports FCS status, length and error flags, which the voting stage and the loss counters consume.

## Interface
- `MAX_LEN`, 1518: maximum bytes after SFD, FCS included. A frame that exceeds it is aborted.
- `clk`  in  1  GMII receive clock; every register is in this domain.
- `rst`  in  1  synchronous, active-low reset.
- `rx_dv`  in  1  GMII data valid.
- `rx_er`  in  1  GMII receive error.
- `rx_data`  in  8  GMII receive byte.
- `rx_enable`  out  1  qualifies `data_out`; high only for body bytes.
- `data_out`  out  8  body byte, driven straight into the voting stage's `rx_data`.
- `frame_done`  out  1  one-cycle pulse at end of every frame that reached PAYLOAD.
- `fcs_ok`  out  1  valid with `frame_done`; CRC residue matched.
- `frame_err`  out  1  valid with `frame_done`; set on rx_er, runt or oversize.
- `frame_len`  out  11  valid with `frame_done`; bytes after SFD, FCS included, saturating at 2047.

## Operation
- States:
  - IDLE
  - PREAMBLE
  - PAYLOAD
  - DROP
- IDLE:
  - `rx_dv`=1 with byte 0x55 -> PREAMBLE.
  - `rx_dv`=1 with byte 0xD5 -> PAYLOAD (zero-length preamble is accepted).
  - `rx_dv`=1 with any other byte -> DROP.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> PAYLOAD; CRC is initialised to 0xFFFFFFFF and the byte counter is cleared.
  - Any other byte, or `rx_er` -> DROP.
  - `rx_dv`=0 -> IDLE with no `frame_done`.
- PAYLOAD:
  - Each byte is fed to the CRC and shifted into a 4-deep delay line; the counter increments.
  - When the delay line already holds 4 bytes, the oldest byte is output with `rx_enable`=1.
  - `rx_dv`=0 -> IDLE. The 4 held bytes (the FCS) are discarded and `frame_done` pulses.
- `fcs_ok` = 1 when the CRC register (no final inversion) after the last byte equals 0xC704DD7B.
- PAYLOAD abort:
  - Triggered by `rx_er`=1, or by the counter reaching `MAX_LEN` while another byte arrives.
  - Action: go to DROP; `rx_enable` drops immediately; `frame_err` is latched.
- DROP: wait for `rx_dv`=0, then go to IDLE. If entered from PAYLOAD, pulse `frame_done` with `fcs_ok`=0 and `frame_err`=1.
- Runt frame: fewer than 4 bytes after SFD -> `frame_err`=1, `fcs_ok`=0. No byte is output.
- Bytes carrying `rx_er` are never forwarded.

## Timing
- Reset values: state IDLE; `rx_enable`, `frame_done`, `fcs_ok` and `frame_err` all 0; `data_out` 0x00; `frame_len` 0; delay line empty.
- Latency: body byte k is visible on `data_out` in the cycle after the edge that samples byte k+4. That is 5 clocks after byte k is on `rx_data`.
- All outputs are registered; no input reaches an output combinationally.
- `rx_enable` is contiguous within a frame. It goes low at the edge that samples `rx_dv`=0.
- `frame_done` asserts on that same edge. `fcs_ok`, `frame_err` and `frame_len` hold until the next `frame_done`.
- Back-to-back frames: one idle cycle (`rx_dv`=0) is enough. The next preamble byte may arrive in the very next cycle after returning to IDLE.
- Reset mid-frame:
  - Everything returns to reset values at the next edge; no `frame_done`.
  - The rest of that frame is ignored until `rx_dv` falls and a new preamble starts. Reset therefore jumps to IDLE, and any non-preamble byte that follows sends the block to DROP.
- Counter and CRC update on the same edge as the delay-line shift. `frame_len` saturates and does not wrap.

## Structure
- A shared `eth_rx_pkg` holds:
  - byte constants `PREAMBLE_BYTE`=0x55 and `SFD_BYTE`=0xD5;
  - `CRC_INIT`=0xFFFFFFFF and `CRC_RESIDUE`=0xC704DD7B;
  - the state enum.
- One sub-module, `crc32_d8`: combinational next-CRC for reflected polynomial 0xEDB88320 over 8 data bits. The same function is reused by the transmit FCS generator.
- The delay line, counter and state machine stay in the top module.

## Test plan
- 7×0x55, 0xD5, then a 64-byte frame with correct FCS:
  - exactly 60 bytes out, identical to the input bytes;
  - `frame_done` once, with `fcs_ok`=1, `frame_err`=0, `frame_len`=64.
- Same frame with body byte 10 XORed with 0x01 -> 60 bytes out, `fcs_ok`=0, `frame_err`=0.
- `rx_er` pulsed on body byte 20:
  - `rx_enable` low from that edge onward; 16 bytes are output before it;
  - `frame_done` with `frame_err`=1 and `fcs_ok`=0 once `rx_dv` falls.
- Preamble 0x55, 0x54, ...:
  - no `rx_enable` and no `frame_done`;
  - a following valid frame after one idle cycle is received correctly.
- 1600-byte frame -> abort at byte 1519; `frame_err`=1, `frame_len`=1518.
- `rst`=0 for one cycle at body byte 30 -> all outputs at reset values; no `frame_done` for that frame; the next valid frame passes with `fcs_ok`=1.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared receive-path definitions: GMII framing byte values, CRC-32
// constants and the framing state machine encoding. Also used by the
// transmit FCS generator through crc32_d8.
package eth_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Reflected IEEE 802.3 polynomial, LSB-first shifting.
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Good-frame residue written in MSB-first bit order. The LSB-first
  // register holds the bit-reversed value (0xDEBB20E3) after a clean FCS.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  localparam int          LEN_W         = 11;
  localparam int          FCS_BYTES     = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  // Bit reversal, converts between LSB-first register and MSB-first constant.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_sfd_strip_if.sv
// Bundle between the GMII receive pins, the framing stage and the voting
// stage.
//   rx_dv/rx_er/rx_data     : GMII receive side
//   rx_enable/data_out      : body byte stream toward the voting stage
//   frame_done/fcs_ok/frame_err/frame_len : end-of-frame report
//   state_dbg               : framing state machine, for observation
//
// Handshake: rx_dv and rx_enable are valid-only strobes. A byte transfers on
// every rising edge where its valid is high; there is no ready, so the
// receiving side must accept every qualified byte.
interface rx_sfd_strip_if;
  import eth_rx_pkg::*;

  logic             rx_dv;
  logic             rx_er;
  logic [7:0]       rx_data;
  logic             rx_enable;
  logic [7:0]       data_out;
  logic             frame_done;
  logic             fcs_ok;
  logic             frame_err;
  logic [LEN_W-1:0] frame_len;
  rx_state_e        state_dbg;

  // Framing stage side.
  modport master (
    input  rx_dv, rx_er, rx_data,
    output rx_enable, data_out, frame_done, fcs_ok, frame_err, frame_len,
           state_dbg
  );

  // Environment side: drives the GMII pins, consumes the stream and report.
  modport slave (
    output rx_dv, rx_er, rx_data,
    input  rx_enable, data_out, frame_done, fcs_ok, frame_err, frame_len,
           state_dbg
  );

endinterface

// File: rtl/crc32_d8.sv
// Combinational next-state of the Ethernet CRC-32 for one data byte,
// LSB-first with the reflected polynomial.
//   crc_in  : current register
//   data    : byte to absorb (bit 0 first on the wire)
//   crc_out : register after the byte
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/rx_sfd_strip.sv
// Receive framing stage: locks onto preamble/SFD, forwards the frame body
// through a 4-byte delay line so the trailing FCS is never emitted, checks
// CRC-32 and reports status at end of frame.
//   clk  : GMII receive clock
//   rst  : synchronous, active-low reset
//   bus  : rx_sfd_strip_if.master (GMII in, body stream and report out)
module rx_sfd_strip
  import eth_rx_pkg::*;
#(
  parameter int MAX_LEN = 1518
) (
  input  logic           clk,
  input  logic           rst,
  rx_sfd_strip_if.master bus
);

  localparam int               LEN_TOP = (1 << LEN_W) - 1;
  localparam int               MAX_CLP = (MAX_LEN > LEN_TOP) ? LEN_TOP : MAX_LEN;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_CLP);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(LEN_TOP);

  rx_state_e         state_q, state_d;
  logic [31:0]       crc_q, crc_d, crc_nxt;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0][7:0]   dly_q, dly_d;      // [3] is the oldest byte
  logic [2:0]        fill_q, fill_d;
  logic              from_pl_q, from_pl_d;  // DROP was entered by a payload abort
  logic              en_q, en_d;
  logic [7:0]        dout_q, dout_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              runt;
  logic              crc_good;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (bus.rx_data),
    .crc_out (crc_nxt)
  );

  assign cnt_inc  = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 1'b1;
  assign runt     = (cnt_q < LEN_W'(FCS_BYTES));
  assign crc_good = (reflect32(crc_q) == CRC_RESIDUE);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    fill_d    = fill_q;
    from_pl_d = from_pl_q;
    en_d      = 1'b0;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = err_q;
    len_d     = len_q;

    case (state_q)
      ST_IDLE: begin
        from_pl_d = 1'b0;
        if (bus.rx_dv) begin
          if (bus.rx_er) begin
            state_d = ST_DROP;
          end else if (bus.rx_data == PREAMBLE_BYTE) begin
            state_d = ST_PREAMBLE;
          end else if (bus.rx_data == SFD_BYTE) begin
            state_d = ST_PAYLOAD;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
            fill_d  = '0;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_d = ST_IDLE;
        end else if (bus.rx_er) begin
          state_d = ST_DROP;
        end else if (bus.rx_data == SFD_BYTE) begin
          state_d = ST_PAYLOAD;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          fill_d  = '0;
        end else if (bus.rx_data != PREAMBLE_BYTE) begin
          state_d = ST_DROP;
        end
      end

      ST_PAYLOAD: begin
        if (!bus.rx_dv) begin
          // End of frame: the 4 held bytes are the FCS and are discarded.
          state_d = ST_IDLE;
          fill_d  = '0;
          done_d  = 1'b1;
          ok_d    = !runt && crc_good;
          err_d   = runt;
          len_d   = cnt_q;
        end else if (bus.rx_er || (cnt_q >= MAX_CNT)) begin
          state_d   = ST_DROP;
          fill_d    = '0;
          from_pl_d = 1'b1;
        end else begin
          crc_d = crc_nxt;
          cnt_d = cnt_inc;
          dly_d = {dly_q[2:0], bus.rx_data};
          if (fill_q == 3'd4) begin
            en_d   = 1'b1;
            dout_d = dly_q[3];
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
      end

      ST_DROP: begin
        if (!bus.rx_dv) begin
          state_d   = ST_IDLE;
          from_pl_d = 1'b0;
          if (from_pl_q) begin
            done_d = 1'b1;
            ok_d   = 1'b0;
            err_d  = 1'b1;
            len_d  = cnt_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC_INIT;
      cnt_q     <= '0;
      dly_q     <= '0;
      fill_q    <= '0;
      from_pl_q <= 1'b0;
      en_q      <= 1'b0;
      dout_q    <= 8'h00;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      from_pl_q <= from_pl_d;
      en_q      <= en_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      len_q     <= len_d;
    end
  end

  assign bus.rx_enable  = en_q;
  assign bus.data_out   = dout_q;
  assign bus.frame_done = done_q;
  assign bus.fcs_ok     = ok_q;
  assign bus.frame_err  = err_q;
  assign bus.frame_len  = len_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_rx_sfd_strip.sv
module tb_rx_sfd_strip;
  import eth_rx_pkg::*;

  localparam int MAX_LEN = 1518;

  typedef struct { int edge_n; logic r; logic dv; logic er; logic [7:0] d; } stim_t;
  typedef struct { int edge_n; logic [7:0] d; } byte_ev_t;
  typedef struct { int edge_n; logic ok; logic err; logic [10:0] len; } done_ev_t;
  typedef struct {
    logic r; logic dv; logic er; logic [7:0] d;
    rx_state_e st; logic done; logic err; logic [10:0] len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  logic        rst_seen = 1'b1;
  logic        mon_on = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  stim_t       stim_q[$];
  byte_ev_t    act_b[$];
  byte_ev_t    exp_b[$];
  done_ev_t    act_d[$];
  done_ev_t    exp_d[$];
  logic [7:0]  fb[$];
  logic [31:0] crc_tab[256];
  vec_t        tbl[16];

  rx_sfd_strip_if bus();

  rx_sfd_strip #(.MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1);
  end

  // ---------------- checking ----------------
  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: log every forwarded byte and report, and check reset values.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_seen == 1'b0) begin
        check("rst_rx_enable",  32'(bus.rx_enable), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_fcs_ok",     32'(bus.fcs_ok), 32'd0);
        check("rst_frame_err",  32'(bus.frame_err), 32'd0);
        check("rst_data_out",   32'(bus.data_out), 32'd0);
        check("rst_frame_len",  32'(bus.frame_len), 32'd0);
        check("rst_state",      32'(bus.state_dbg), 32'(ST_IDLE));
      end
      if (bus.rx_enable === 1'b1) act_b.push_back('{cyc, bus.data_out});
      if (bus.frame_done === 1'b1)
        act_d.push_back('{cyc, bus.fcs_ok, bus.frame_err, bus.frame_len});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rst         = r;
    bus.rx_dv   = dv;
    bus.rx_er   = er;
    bus.rx_data = d;
    stim_q.push_back('{cyc + 1, r, dv, er, d});
  endtask

  function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
    return (c >> 8) ^ crc_tab[c[7:0] ^ b];
  endfunction

  // Random payload followed by its correct FCS (complemented CRC, LSB first).
  task automatic make_frame(input int n_pay);
    logic [31:0] c;
    logic [7:0]  b;
    fb.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_pay; i++) begin
      b = 8'($urandom_range(0, 255));
      fb.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    fb.push_back(c[23:16]);
    fb.push_back(c[31:24]);
  endtask

  task automatic drive_frame(input int pre_n, input int er_at, input int rst_at);
    repeat (pre_n) drive(1'b1, 1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < fb.size(); i++)
      drive((i == rst_at) ? 1'b0 : 1'b1, 1'b1, (i == er_at), fb[i]);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- reference model ----------------
  // Works on bursts: maximal runs of cycles with rx_dv=1 outside reset.
  // A burst is a frame when it is zero or more 0x55 then 0xD5 with no rx_er.
  function automatic void model_segment(int s, int e);
    int          k;
    int          acc;
    logic        aborted;
    logic [7:0]  bq[$];
    int          be[$];
    logic [31:0] c;
    logic        match;
    k = s;
    while (k < e && !stim_q[k].er && stim_q[k].d == 8'h55) k++;
    if (k == e) return;
    if (stim_q[k].er || stim_q[k].d != 8'hD5) return;
    aborted = 1'b0;
    for (int i = k + 1; i < e; i++) begin
      if (!aborted && (stim_q[i].er || bq.size() >= MAX_LEN)) aborted = 1'b1;
      if (!aborted) begin
        bq.push_back(stim_q[i].d);
        be.push_back(stim_q[i].edge_n);
      end
    end
    acc = bq.size();
    for (int b = 0; b + 4 < acc; b++) exp_b.push_back('{be[b + 4], bq[b]});
    if (e < stim_q.size() && stim_q[e].r && !stim_q[e].dv) begin
      match = 1'b0;
      if (acc >= 4) begin
        c = 32'hFFFFFFFF;
        for (int b = 0; b < acc - 4; b++) c = crc_upd(c, bq[b]);
        c = ~c;
        match = (bq[acc-4] == c[7:0]) && (bq[acc-3] == c[15:8]) &&
                (bq[acc-2] == c[23:16]) && (bq[acc-1] == c[31:24]);
      end
      exp_d.push_back('{stim_q[e].edge_n, !aborted && match, aborted || (acc < 4),
                        11'((acc > 2047) ? 2047 : acc)});
    end
  endfunction

  function automatic void run_model();
    int i;
    int j;
    exp_b.delete();
    exp_d.delete();
    i = 0;
    while (i < stim_q.size()) begin
      if (!stim_q[i].r || !stim_q[i].dv) begin
        i++;
      end else begin
        j = i;
        while (j < stim_q.size() && stim_q[j].r && stim_q[j].dv) j++;
        model_segment(i, j);
        i = j;
      end
    end
  endfunction

  // Flush, compare log against model, then optional fixed expectations.
  task automatic check_scenario(input int nb, input int nd, input logic ok,
                                input logic err, input int len);
    int n;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    run_model();
    check("model_nbytes", act_b.size(), exp_b.size());
    n = (act_b.size() < exp_b.size()) ? act_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) begin
      check("byte_edge", act_b[i].edge_n, exp_b[i].edge_n);
      check("byte_data", 32'(act_b[i].d), 32'(exp_b[i].d));
    end
    check("model_ndone", act_d.size(), exp_d.size());
    n = (act_d.size() < exp_d.size()) ? act_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check("done_edge", act_d[i].edge_n, exp_d[i].edge_n);
      check("done_fcs_ok", 32'(act_d[i].ok), 32'(exp_d[i].ok));
      check("done_frame_err", 32'(act_d[i].err), 32'(exp_d[i].err));
      check("done_frame_len", 32'(act_d[i].len), 32'(exp_d[i].len));
    end
    if (nb >= 0) begin
      check("plan_nbytes", act_b.size(), nb);
      check("plan_ndone", act_d.size(), nd);
      if (nd > 0 && act_d.size() > 0) begin
        check("plan_fcs_ok", 32'(act_d[act_d.size()-1].ok), 32'(ok));
        check("plan_frame_err", 32'(act_d[act_d.size()-1].err), 32'(err));
        check("plan_frame_len", 32'(act_d[act_d.size()-1].len), len);
      end
    end
    stim_q.delete();
    act_b.delete();
    act_d.delete();
  endtask

  task automatic random_frame();
    int mode;
    int pre_n;
    int er_at;
    int rst_at;
    int n;
    pre_n  = $urandom_range(0, 8);
    er_at  = -1;
    rst_at = -1;
    make_frame($urandom_range(0, 70));
    mode = $urandom_range(0, 9);
    case (mode)
      0: begin
        n = $urandom_range(0, fb.size() - 1);
        fb[n] = fb[n] ^ (8'h01 << $urandom_range(0, 7));
      end
      1: er_at  = $urandom_range(0, fb.size() - 1);
      2: rst_at = $urandom_range(0, fb.size() - 1);
      3: begin
        n = $urandom_range(0, 3);
        while (fb.size() > n) void'(fb.pop_back());
      end
      4: begin
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 8'h54)));
      end
      default: ;
    endcase
    drive_frame(pre_n, er_at, rst_at);
    repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end

    //        r     dv    er    data   state        done  err   len
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE,     1'b0, 1'b0, 11'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h55, ST_PREAMBLE, 1'b0, 1'b0, 11'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h55, ST_PREAMBLE, 1'b0, 1'b0, 11'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h54, ST_DROP,     1'b0, 1'b0, 11'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hD5, ST_DROP,     1'b0, 1'b0, 11'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, ST_IDLE,     1'b0, 1'b0, 11'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'hD5, ST_PAYLOAD,  1'b0, 1'b0, 11'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h11, ST_PAYLOAD,  1'b0, 1'b0, 11'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, ST_IDLE,     1'b1, 1'b1, 11'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h55, ST_PREAMBLE, 1'b0, 1'b1, 11'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h55, ST_DROP,     1'b0, 1'b1, 11'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, ST_IDLE,     1'b0, 1'b1, 11'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h55, ST_PREAMBLE, 1'b0, 1'b1, 11'd1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h00, ST_IDLE,     1'b0, 1'b1, 11'd1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h07, ST_DROP,     1'b0, 1'b1, 11'd1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h00, ST_IDLE,     1'b0, 1'b1, 11'd1};

    bus.rx_dv   = 1'b0;
    bus.rx_er   = 1'b0;
    bus.rx_data = 8'h00;
    rst         = 1'b0;
    mon_on      = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Per-cycle state machine vectors, including a runt frame.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].dv, tbl[i].er, tbl[i].d);
      @(posedge clk);
      #1;
      check("tbl_state", 32'(bus.state_dbg), 32'(tbl[i].st));
      check("tbl_frame_done", 32'(bus.frame_done), 32'(tbl[i].done));
      check("tbl_rx_enable", 32'(bus.rx_enable), 32'd0);
      check("tbl_fcs_ok", 32'(bus.fcs_ok), 32'd0);
      check("tbl_frame_err", 32'(bus.frame_err), 32'(tbl[i].err));
      check("tbl_frame_len", 32'(bus.frame_len), 32'(tbl[i].len));
    end
    check_scenario(-1, 0, 1'b0, 1'b0, 0);

    // Good 64-byte frame.
    make_frame(60);
    drive_frame(7, -1, -1);
    check_scenario(60, 1, 1'b1, 1'b0, 64);

    // Same frame with body byte 10 corrupted.
    fb[10] = fb[10] ^ 8'h01;
    drive_frame(7, -1, -1);
    check_scenario(60, 1, 1'b0, 1'b0, 64);

    // rx_er on body byte 20.
    make_frame(60);
    drive_frame(7, 20, -1);
    check_scenario(16, 1, 1'b0, 1'b1, 20);

    // Broken preamble burst, one idle cycle, then a good frame.
    drive(1'b1, 1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b1, 1'b0, 8'h54);
    make_frame(60);
    drive_frame(5, -1, -1);
    make_frame(60);
    drive_frame(7, -1, -1);
    check_scenario(60, 1, 1'b1, 1'b0, 64);

    // Oversize frame aborted after MAX_LEN bytes.
    make_frame(1596);
    drive_frame(7, -1, -1);
    check_scenario(1514, 1, 1'b0, 1'b1, 1518);

    // Reset at body byte 30; the rest of the burst must not start a frame.
    make_frame(60);
    fb[31] = 8'h00;
    drive_frame(7, -1, 30);
    check_scenario(26, 0, 1'b0, 1'b0, 0);
    make_frame(60);
    drive_frame(7, -1, -1);
    check_scenario(60, 1, 1'b1, 1'b0, 64);

    // Randomised back-to-back traffic against the model.
    for (int g = 0; g < 12; g++) begin
      repeat (4) random_frame();
      check_scenario(-1, 0, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
